indexed_bitmap_tracker: RTL
===========================

Name: indexed_bitmap_tracker

Overview:
- Parametrised pointer-driven bitmap tracker with an auto-advancing index counter.
- Each advance sets the bit at the old pointer in a forward bitmap, and the bit at the mirrored old pointer in a flip bitmap.
- Adds over the single-width original: configurable width and stride, single-bit clear, registered population count, and full/done status.
- Sits beside per-slot allocators and scoreboards as a visited/occupied tracker.

Parameters:
- WIDTH, 8, bitmap width; power of two, ≥2.
- IDXW, $clog2(WIDTH), pointer/index width; derived, not overridden.
- STEP, 1, pointer increment per advance, applied modulo WIDTH; 1..WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  clear both bitmaps and load pointer.
- start_idx  in  IDXW  pointer value loaded on start.
- step_en  in  1  set bits at old pointer; advance pointer.
- clr_en  in  1  clear one bit pair.
- clr_idx  in  IDXW  index for clear.
- ptr  out  IDXW  current pointer.
- vec  out  WIDTH  forward bitmap.
- vec_flip  out  WIDTH  mirrored bitmap.
- count  out  IDXW+1  number of ones in vec.
- full  out  1  vec is all ones.
- done  out  1  one-cycle pulse when vec first becomes all ones.

Behaviour:
- Reset (async, rst=1): ptr=0, vec=0, vec_flip=0, count=0, done=0. full is derived from vec, so full=0.
- Mirror index: mir(i) = WIDTH-1-i, which equals the bitwise NOT of i for power-of-two WIDTH.
- Priority per cycle: start > (clear, set) > hold.
- start=1:
  - vec<=0, vec_flip<=0, ptr<=start_idx, count<=0, done<=0.
  - step_en and clr_en are ignored that cycle.
- step_en=1 (start=0):
  - vec[ptr]<=1 and vec_flip[mir(ptr)]<=1, both using the pre-edge ptr.
  - ptr<=(ptr+STEP) mod WIDTH; natural IDXW-bit wrap.
- clr_en=1 (start=0): vec[clr_idx]<=0, vec_flip[mir(clr_idx)]<=0.
- Same-index collision (step_en and clr_en, with ptr==clr_idx): clear wins, so the bit ends at 0. The pointer still advances.
- Different-index clear and set in the same cycle: both take effect.
- Setting an already-set bit is a no-op; the pointer still advances.
- Latency: all outputs are registered and reflect an operation one edge after it is sampled.
- count: registered, computed from the next value of vec, so count always matches vec in the same cycle.
- full: combinational (&vec).
- done:
  - Registered; asserted for exactly one cycle, in the cycle vec first equals all ones.
  - Condition: next vec is all ones and current vec is not.
  - Re-arms only after vec drops below full (clear or start).
- Staying full does not re-pulse done.
- Coverage with STEP: when STEP is even, some indices are unreachable by stepping, so full is reached only if those bits were never cleared from a prior fill. Bits are never set except by step_en.
- Reset mid-operation: immediate clear of all state, regardless of clock. Release is synchronous to the next edge (rst deasserted before the sampling edge).

Decomposition:
- Shared package indexed_bitmap_pkg:
  - function mirror_idx(i, WIDTH).
  - localparam IDXW derivation helper.
- One sub-module: bitmap_popcount (WIDTH in, IDXW+1 out, combinational adder tree), instantiated on the next-vec value.

Test Plan:
- WIDTH=8, STEP=1; start with start_idx=1, then step_en for 2 cycles -> vec=8'h06, vec_flip=8'h60, ptr=3, count=2, full=0.
- Wrap: start with start_idx=6, then 3 steps -> ptr=1, vec=8'hC1, vec_flip=8'h83, count=3.
- Collision: start with start_idx=2; step_en with clr_en and clr_idx=2 -> vec=0, ptr=3. Next, step_en with clr_en and clr_idx=5 -> vec=8'h08, vec_flip=8'h10.
- Full/done with STEP=3: start with start_idx=0, then 8 steps -> visits 0,3,6,1,4,7,2,5; vec=8'hFF, count=8, full=1, done high exactly one cycle. Further steps -> no done. clr_idx=4 then step at ptr=4 -> done pulses again.
- STEP=2: start with start_idx=0, then 8 steps -> vec=8'h55, vec_flip=8'hAA, count=4, full=0, done never asserts.
- Async reset: assert rst mid-sequence between clock edges -> all outputs zero before the next edge. Deassert, then start with start_idx=1 and 2 steps -> 8'h06 / 8'h60 again.

Source files
------------

// File: rtl/indexed_bitmap_pkg.sv
// Shared types and helpers for the indexed bitmap tracker: index width derivation
// and the mirror-index mapping used by the flip bitmap.
package indexed_bitmap_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_STEP  = 1;

    // Pointer width for a given bitmap width; WIDTH is a power of two >= 2.
    function automatic int idx_width(input int width);
        return $clog2(width);
    endfunction

    // Mirrored position of index i; equals ~i for power-of-two widths.
    function automatic int mirror_idx(input int i, input int width);
        return width - 1 - i;
    endfunction

endpackage

// File: rtl/indexed_bitmap_tracker_if.sv
// Control/status bundle of the indexed bitmap tracker; the master drives commands,
// the slave (the tracker) returns pointer, bitmaps and status.
interface indexed_bitmap_tracker_if
    import indexed_bitmap_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    localparam int IDXW = idx_width(WIDTH);

    logic            start;
    logic [IDXW-1:0] start_idx;
    logic            step_en;
    logic            clr_en;
    logic [IDXW-1:0] clr_idx;

    logic [IDXW-1:0] ptr;
    logic [WIDTH-1:0] vec;
    logic [WIDTH-1:0] vec_flip;
    logic [IDXW:0]   count;
    logic            full;
    logic            done;

    modport master (
        output start, start_idx, step_en, clr_en, clr_idx,
        input  ptr, vec, vec_flip, count, full, done
    );

    modport slave (
        input  start, start_idx, step_en, clr_en, clr_idx,
        output ptr, vec, vec_flip, count, full, done
    );

endinterface

// File: rtl/indexed_bitmap_tracker_popcount.sv
// Combinational population count of a power-of-two-wide vector, built as a
// balanced pairwise adder tree with one generate level per halving.
module bitmap_popcount
    import indexed_bitmap_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDXW  = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDXW:0]    count_o
);

    // Level l holds WIDTH>>l partial sums; the single node at level IDXW is the total.
    for (genvar l = 0; l <= IDXW; l++) begin : g_lvl
        localparam int N = WIDTH >> l;
        logic [IDXW:0] node [N];

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign node[i] = (IDXW + 1)'(vec_i[i]);
            end
        end else begin : g_sum
            for (genvar i = 0; i < N; i++) begin : g_pair
                assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
            end
        end
    end

    assign count_o = g_lvl[IDXW].node[0];

endmodule

// File: rtl/indexed_bitmap_tracker.sv
// Pointer-driven visited/occupied tracker: each advance marks the old pointer in a
// forward bitmap and its mirror in a flip bitmap, with clear, popcount and full/done.
module indexed_bitmap_tracker
    import indexed_bitmap_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int STEP  = DEFAULT_STEP,
    localparam int IDXW  = idx_width(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    indexed_bitmap_tracker_if.slave bus
);

    localparam logic [IDXW-1:0] STEP_W = IDXW'(STEP);

    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [WIDTH-1:0] flip_q, flip_d;
    logic [IDXW:0]    count_q, count_d;
    logic             done_q, done_d;

    logic [IDXW-1:0]  ptr_mir;
    logic [IDXW-1:0]  clr_mir;

    assign ptr_mir = IDXW'(mirror_idx(int'(ptr_q), WIDTH));
    assign clr_mir = IDXW'(mirror_idx(int'(bus.clr_idx), WIDTH));

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        ptr_d  = ptr_q;
        vec_d  = vec_q;
        flip_d = flip_q;
        done_d = 1'b0;

        if (bus.start) begin
            ptr_d  = bus.start_idx;
            vec_d  = '0;
            flip_d = '0;
        end else begin
            if (bus.step_en) begin
                vec_d[ptr_q]    = 1'b1;
                flip_d[ptr_mir] = 1'b1;
                ptr_d           = ptr_q + STEP_W;
            end
            // Applied after the set so a same-index collision leaves the bit clear.
            if (bus.clr_en) begin
                vec_d[bus.clr_idx] = 1'b0;
                flip_d[clr_mir]    = 1'b0;
            end
            done_d = (&vec_d) && !(&vec_q);
        end
    end

    // Count is taken from the next bitmap so the registered value tracks vec exactly.
    bitmap_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .vec_i   (vec_d),
        .count_o (count_d)
    );

    // NOTE: the bitmaps are ordinary flops rather than a RAM, so they take the
    // asynchronous reset along with the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            vec_q   <= '0;
            flip_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            ptr_q   <= ptr_d;
            vec_q   <= vec_d;
            flip_q  <= flip_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign bus.ptr      = ptr_q;
    assign bus.vec      = vec_q;
    assign bus.vec_flip = flip_q;
    assign bus.count    = count_q;
    assign bus.full     = &vec_q;
    assign bus.done     = done_q;

endmodule
